// File: rtl/imem_dmem_arbiter_pkg.sv
// Shared types and constants for the instruction/data memory arbiter.
package imem_dmem_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } arb_state_t;

  typedef enum logic {
    FETCH = 1'b0,
    DATA  = 1'b1
  } arb_owner_t;

  localparam logic [3:0] MEM_NOP_WE = 4'b0000;

endpackage

// File: rtl/imem_dmem_arbiter_arb_pick.sv
// Combinational winner selection between fetch and data requesters.
// With enable low, data always beats fetch; with enable high the side that lost last time wins.
module imem_dmem_arbiter_arb_pick
  import imem_dmem_arbiter_pkg::*;
(
  input  logic       if_req,
  input  logic       d_req,
  input  arb_owner_t last_owner,
  input  logic       enable,
  output arb_owner_t owner
);

  // Resolve contention; a lone requester always wins.
  always_comb begin
    owner = FETCH;
    if (if_req && d_req) begin
      if (enable && (last_owner == DATA)) begin
        owner = FETCH;
      end else begin
        owner = DATA;
      end
    end else if (d_req) begin
      owner = DATA;
    end else begin
      owner = FETCH;
    end
  end

endmodule

// File: rtl/imem_dmem_arbiter.sv
// Shares one synchronous-read memory between the fetch and data ports, one transaction at a time.
// Define ARB_ROUND_ROBIN_EN to replace fixed data-over-fetch priority with alternating priority.
module imem_dmem_arbiter
  import imem_dmem_arbiter_pkg::*;
#(
  parameter int READ_LATENCY = 2,
  parameter int CNT_WIDTH    = 3
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        if_req_in,
  input  logic [31:0] if_addr_in,
  output logic        if_gnt_out,
  output logic        if_rvalid_out,
  output logic [31:0] if_rdata_out,
  input  logic        d_req_in,
  input  logic [31:0] d_addr_in,
  input  logic [31:0] d_wdata_in,
  input  logic [3:0]  d_we_in,
  output logic        d_gnt_out,
  output logic        d_rvalid_out,
  output logic [31:0] d_rdata_out,
  output logic [31:0] mem_addr_out,
  output logic [31:0] mem_data_out,
  output logic [3:0]  mem_we_out,
  input  logic [31:0] mem_data_in
);

  arb_state_t           state_r;
  arb_state_t           state_next_s;
  logic [CNT_WIDTH-1:0] cnt_r;
  arb_owner_t           rd_owner_r;
  logic [31:0]          addr_r;
  logic [31:0]          data_r;
  arb_owner_t           winner_s;
  arb_owner_t           last_owner_s;
  logic                 rr_en_s;
  logic                 grant_ok_s;
  logic                 if_gnt_s;
  logic                 d_gnt_s;
  logic                 rd_gnt_s;

`ifdef ARB_ROUND_ROBIN_EN
  arb_owner_t last_owner_r;

  // Remember who owned the most recent grant, reads and writes alike.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      last_owner_r <= FETCH;
    end else if (if_gnt_s || d_gnt_s) begin
      last_owner_r <= d_gnt_s ? DATA : FETCH;
    end
  end

  assign last_owner_s = last_owner_r;
  assign rr_en_s      = 1'b1;
`else
  assign last_owner_s = FETCH;
  assign rr_en_s      = 1'b0;
`endif

  imem_dmem_arbiter_arb_pick u_arb_pick (
    .if_req     (if_req_in),
    .d_req      (d_req_in),
    .last_owner (last_owner_s),
    .enable     (rr_en_s),
    .owner      (winner_s)
  );

  // The memory port is free in IDLE and in the response cycle of the previous read.
  assign grant_ok_s = (state_r == IDLE) || (state_r == RESP);
  assign d_gnt_s    = grant_ok_s && d_req_in && (winner_s == DATA);
  assign if_gnt_s   = grant_ok_s && if_req_in && (winner_s == FETCH);
  assign rd_gnt_s   = if_gnt_s || (d_gnt_s && (d_we_in == MEM_NOP_WE));

  // State register, latency counter, read owner and the held memory address/data.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_r    <= IDLE;
      cnt_r      <= {CNT_WIDTH{1'b0}};
      rd_owner_r <= FETCH;
      addr_r     <= 32'h0000_0000;
      data_r     <= 32'h0000_0000;
    end else begin
      state_r <= state_next_s;
      if (rd_gnt_s) begin
        cnt_r      <= CNT_WIDTH'(READ_LATENCY - 1);
        rd_owner_r <= d_gnt_s ? DATA : FETCH;
      end else if (state_r == WAIT) begin
        cnt_r <= cnt_r - CNT_WIDTH'(1);
      end
      if (if_gnt_s || d_gnt_s) begin
        addr_r <= mem_addr_out;
        data_r <= mem_data_out;
      end
    end
  end

  // Next-state logic; writes never leave IDLE because they have no response.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE, RESP: begin
        if (rd_gnt_s) begin
          state_next_s = (READ_LATENCY == 1) ? RESP : WAIT;
        end else begin
          state_next_s = IDLE;
        end
      end
      WAIT: begin
        if (cnt_r == CNT_WIDTH'(1)) begin
          state_next_s = RESP;
        end else begin
          state_next_s = WAIT;
        end
      end
      default: state_next_s = IDLE;
    endcase
  end

  // Output logic: memory port follows the granted requester, otherwise holds its last value.
  always_comb begin
    if_gnt_out   = if_gnt_s;
    d_gnt_out    = d_gnt_s;
    mem_addr_out = addr_r;
    mem_data_out = data_r;
    mem_we_out   = MEM_NOP_WE;
    if (d_gnt_s) begin
      mem_addr_out = d_addr_in;
      mem_data_out = d_wdata_in;
      mem_we_out   = d_we_in;
    end else if (if_gnt_s) begin
      mem_addr_out = if_addr_in;
      mem_data_out = data_r;
      mem_we_out   = MEM_NOP_WE;
    end else begin
      mem_addr_out = addr_r;
      mem_data_out = data_r;
      mem_we_out   = MEM_NOP_WE;
    end
    if_rvalid_out = (state_r == RESP) && (rd_owner_r == FETCH);
    d_rvalid_out  = (state_r == RESP) && (rd_owner_r == DATA);
    if_rdata_out  = mem_data_in;
    d_rdata_out   = mem_data_in;
  end

endmodule
